bitfusion_seq_ctrl: RTL and testbench

Sequencer for one `bitfusion_top` fusion-unit slice. It computes a dot product of `len` 8-bit input/weight pairs held in an operand buffer. It streams the pairs through the fusion unit, tracks in-flight results with a valid pipeline, and accumulates `psum_fwd` into a wide result. Start/busy/done handshake to the layer controller above.

---
 rtl/bitfusion_pkg.sv | 19 +
 rtl/bf_valid_pipe.sv | 30 +++
 rtl/bitfusion_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_bitfusion_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bitfusion_pkg.sv
// Shared definitions for the bitfusion fusion-unit slice and its sequencer.
package bitfusion_pkg;

    localparam int BF_OPND_W = 8;
    localparam int BF_PSUM_W = 19;

    typedef enum logic [1:0] {
        BF_IDLE  = 2'd0,
        BF_ISSUE = 2'd1,
        BF_DRAIN = 2'd2,
        BF_DONE  = 2'd3
    } bf_seq_state_t;

    // Fill bit used when widening a partial sum into the accumulator.
    function automatic logic bf_ext_fill(input logic [BF_PSUM_W-1:0] psum, input logic is_signed);
        return is_signed & psum[BF_PSUM_W-1];
    endfunction

endpackage

// File: rtl/bf_valid_pipe.sv
// Valid-tag shift register aligning operand tags with the fusion unit's partial sums.
module bf_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    output logic vld_out,
    output logic any_vld
);

    logic [DEPTH-1:0] r_sh;
    logic [DEPTH:0]   w_chain;

    assign w_chain = {r_sh, vld_in};

    // Shift tags one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= {DEPTH{1'b0}};
        end else begin
            r_sh <= w_chain[DEPTH-1:0];
        end
    end

    assign vld_out = r_sh[DEPTH-1];
    // Tags still outstanding after this edge: the entering one plus all not yet exiting.
    assign any_vld = |w_chain[DEPTH-1:0];

endmodule

// File: rtl/bitfusion_seq_ctrl.sv
// Dot-product sequencer: issues buffer reads, streams operand pairs into one
// bitfusion_top slice and accumulates the returned partial sums.
module bitfusion_seq_ctrl
    import bitfusion_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 8,
    parameter int FU_LAT = 2,
    parameter int ACC_W  = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 s_in_cfg,
    input  logic                 s_weight_cfg,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     result,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [BF_OPND_W-1:0] rd_in,
    input  logic [BF_OPND_W-1:0] rd_weight,
    output logic [BF_OPND_W-1:0] fu_in,
    output logic [BF_OPND_W-1:0] fu_weight,
    output logic [BF_PSUM_W-1:0] fu_psum_in,
    output logic                 fu_s_in,
    output logic                 fu_s_weight,
    input  logic [BF_PSUM_W-1:0] fu_psum_fwd
);

    localparam logic [LEN_W-1:0] LP_CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    bf_seq_state_t     r_state;
    bf_seq_state_t     w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_ret_vld;
    logic              r_busy;
    logic              r_done;
    logic              r_s_in;
    logic              r_s_w;
    logic [ACC_W-1:0]  r_result;
    logic              w_start_ok;
    logic              w_issue_more;
    logic              w_vld_out;
    logic              w_any_vld;
    logic [ACC_W-1:0]  w_psum_ext;

    assign w_start_ok   = (r_state == BF_IDLE) & start;
    assign w_issue_more = (r_state == BF_ISSUE) & (r_cnt != r_len);
    assign w_psum_ext   = {{(ACC_W-BF_PSUM_W){bf_ext_fill(fu_psum_fwd, r_s_in | r_s_w)}}, fu_psum_fwd};

    bf_valid_pipe #(
        .DEPTH (FU_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (r_ret_vld),
        .vld_out (w_vld_out),
        .any_vld (w_any_vld)
    );

    // Next-state selection for the sequencer FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BF_IDLE: begin
                if (start) begin
                    if (len == {LEN_W{1'b0}}) begin
                        w_state_nxt = BF_DONE;
                    end else begin
                        w_state_nxt = BF_ISSUE;
                    end
                end else begin
                    w_state_nxt = BF_IDLE;
                end
            end
            BF_ISSUE: begin
                if (r_cnt == r_len) begin
                    w_state_nxt = BF_DRAIN;
                end else begin
                    w_state_nxt = BF_ISSUE;
                end
            end
            BF_DRAIN: begin
                if (!w_any_vld) begin
                    w_state_nxt = BF_DONE;
                end else begin
                    w_state_nxt = BF_DRAIN;
                end
            end
            BF_DONE:  w_state_nxt = BF_IDLE;
            default:  w_state_nxt = BF_IDLE;
        endcase
    end

    // State, handshake outputs, read counter and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= BF_IDLE;
            r_len     <= {LEN_W{1'b0}};
            r_cnt     <= {LEN_W{1'b0}};
            r_base    <= {ADDR_W{1'b0}};
            r_rd_addr <= {ADDR_W{1'b0}};
            r_rd_en   <= 1'b0;
            r_ret_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s_in    <= 1'b0;
            r_s_w     <= 1'b0;
            r_result  <= {ACC_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != BF_IDLE);
            r_done    <= (w_state_nxt == BF_DONE);
            r_rd_en   <= (w_state_nxt == BF_ISSUE);
            r_ret_vld <= r_rd_en;
            if (w_start_ok) begin
                r_len     <= len;
                r_base    <= base_addr;
                r_s_in    <= s_in_cfg;
                r_s_w     <= s_weight_cfg;
                r_cnt     <= LP_CNT_ONE;
                r_rd_addr <= base_addr;
                r_result  <= {ACC_W{1'b0}};
            end else begin
                if (w_issue_more) begin
                    r_cnt     <= r_cnt + LP_CNT_ONE;
                    r_rd_addr <= r_base + ADDR_W'(r_cnt);
                end
                if (w_vld_out) begin
                    r_result <= r_result + w_psum_ext;
                end
                if (w_state_nxt == BF_IDLE) begin
                    r_s_in <= 1'b0;
                    r_s_w  <= 1'b0;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    // Read data feeds the fusion unit directly; idle slots present zero operands.
    assign fu_in       = r_ret_vld ? rd_in : {BF_OPND_W{1'b0}};
    assign fu_weight   = r_ret_vld ? rd_weight : {BF_OPND_W{1'b0}};
    assign fu_psum_in  = {BF_PSUM_W{1'b0}};
    assign fu_s_in     = r_s_in;
    assign fu_s_weight = r_s_w;

endmodule

// File: tb/tb_bitfusion_seq_ctrl.sv
// Directed bench for bitfusion_seq_ctrl with a buffer model and a 2-cycle fusion-unit model.
module tb_bitfusion_seq_ctrl;

    localparam int LEN_W  = 8;
    localparam int ADDR_W = 8;
    localparam int FU_LAT = 2;
    localparam int ACC_W  = 27;

    logic              clk;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base_addr;
    logic              s_in_cfg;
    logic              s_weight_cfg;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_in;
    logic [7:0]        rd_weight;
    logic [7:0]        fu_in;
    logic [7:0]        fu_weight;
    logic [18:0]       fu_psum_in;
    logic              fu_s_in;
    logic              fu_s_weight;
    logic [18:0]       fu_psum_fwd;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_in [0:255];
    logic [7:0]  mem_w  [0:255];
    logic [18:0] fu_st1;
    logic [18:0] fu_st2;

    bitfusion_seq_ctrl #(
        .LEN_W  (LEN_W),
        .ADDR_W (ADDR_W),
        .FU_LAT (FU_LAT),
        .ACC_W  (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .base_addr    (base_addr),
        .s_in_cfg     (s_in_cfg),
        .s_weight_cfg (s_weight_cfg),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_in        (rd_in),
        .rd_weight    (rd_weight),
        .fu_in        (fu_in),
        .fu_weight    (fu_weight),
        .fu_psum_in   (fu_psum_in),
        .fu_s_in      (fu_s_in),
        .fu_s_weight  (fu_s_weight),
        .fu_psum_fwd  (fu_psum_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] fu_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic sa, input logic sb);
        logic signed [8:0]  ea;
        logic signed [8:0]  eb;
        logic signed [17:0] p;
        ea = $signed({sa & a[7], a});
        eb = $signed({sb & b[7], b});
        p  = ea * eb;
        return {p[17], p};
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            rd_in     <= mem_in[rd_addr];
            rd_weight <= mem_w[rd_addr];
        end
    end

    always @(posedge clk) begin
        fu_st1 <= fu_mul(fu_in, fu_weight, fu_s_in, fu_s_weight);
        fu_st2 <= fu_st1;
    end
    assign fu_psum_fwd = fu_st2;

    typedef struct {
        int          len;
        logic [7:0]  base;
        logic        s_in;
        logic        s_w;
        logic [63:0] in_v;
        logic [63:0] w_v;
        logic [26:0] exp_res;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit glitch);
        int rd_cnt, first, last, addr_bad, sgn_bad, done_cyc, done_cnt;
        logic [ACC_W-1:0] res_at_done;
        logic [7:0] a;
        for (int i = 0; i < v.len; i++) begin
            a = v.base + 8'(i);
            mem_in[a] = v.in_v[i*8 +: 8];
            mem_w[a]  = v.w_v[i*8 +: 8];
        end
        @(negedge clk);
        len = v.len[7:0]; base_addr = v.base;
        s_in_cfg = v.s_in; s_weight_cfg = v.s_w; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; len = 8'd1; base_addr = 8'h99;
        s_in_cfg = ~v.s_in; s_weight_cfg = ~v.s_w;
        rd_cnt = 0; first = -1; last = -1; addr_bad = 0; sgn_bad = 0;
        done_cyc = 0; done_cnt = 0; res_at_done = '0;
        for (int k = 1; k <= v.len + FU_LAT + 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en === 1'b1) begin
                if (first < 0) first = k;
                last = k;
                if (rd_addr !== v.base + 8'(rd_cnt)) addr_bad++;
                rd_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    res_at_done = result;
                end
            end
            if (busy === 1'b1 && (fu_s_in !== v.s_in || fu_s_weight !== v.s_w)) sgn_bad++;
            if (glitch && (k == 2 || k == v.len + 2)) begin
                start = 1'b1; len = 8'd0; base_addr = 8'h55;
            end
        end
        chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({nm, "_result_at_done"}, 64'(res_at_done), 64'(v.exp_res));
        chk({nm, "_result_held"}, 64'(result), 64'(v.exp_res));
        chk({nm, "_rd_count"}, 64'(rd_cnt), 64'(v.len));
        chk({nm, "_rd_first"}, 64'(first), (v.len == 0) ? -64'sd1 : 64'd1);
        chk({nm, "_rd_last"}, 64'(last), (v.len == 0) ? -64'sd1 : 64'(v.len));
        chk({nm, "_rd_addr_seq"}, 64'(addr_bad), 64'd0);
        chk({nm, "_sign_cfg"}, 64'(sgn_bad), 64'd0);
        chk({nm, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        vec_t rv;
        // Operand lists are packed with element 0 in the lowest byte.
        vecs[0] = '{4, 8'h00, 1'b0, 1'b0, 64'h04030201, 64'h08070605, 27'd70, 8};
        vecs[1] = '{2, 8'h10, 1'b1, 1'b1, 64'h02FF, 64'hFC03, 27'h7FFFFF5, 6};
        vecs[2] = '{4, 8'hFE, 1'b0, 1'b0, 64'h281E140A, 64'h04030201, 27'd300, 8};
        vecs[3] = '{0, 8'h33, 1'b0, 1'b0, 64'h0, 64'h0, 27'd0, 1};
        vecs[4] = '{1, 8'h80, 1'b1, 1'b0, 64'h80, 64'hFF, 27'h7FF8080, 5};
        vecs[5] = '{3, 8'h00, 1'b0, 1'b0, 64'hFFFFFF, 64'hFFFFFF, 27'd195075, 7};
        vecs[6] = '{8, 8'h40, 1'b0, 1'b1, 64'h0807060504030201, 64'hFFFFFFFFFFFFFFFF, 27'h7FFFFDC, 12};

        rst = 1'b1; start = 1'b0; len = 8'd0; base_addr = 8'd0;
        s_in_cfg = 1'b0; s_weight_cfg = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {busy, done, rd_en, rd_addr, fu_s_in, fu_s_weight}, 64'd0);
        chk("reset_data", {result, fu_in, fu_weight, fu_psum_in}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 7; n++) begin
            run_vec(vecs[n], $sformatf("v%0d", n), 1'b0);
        end

        run_vec(vecs[0], "glitch", 1'b1);

        // Reset in cycle 3 of a len=8 run, then a short run must see only its own pairs.
        rv = vecs[6];
        for (int i = 0; i < 8; i++) begin
            mem_in[8'h40 + 8'(i)] = rv.in_v[i*8 +: 8];
            mem_w[8'h40 + 8'(i)]  = rv.w_v[i*8 +: 8];
        end
        @(negedge clk);
        len = 8'd8; base_addr = 8'h40; s_in_cfg = 1'b0; s_weight_cfg = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {busy, done, rd_en, rd_addr, fu_s_in, fu_s_weight}, 64'd0);
        chk("rst_mid_data", {result, fu_in, fu_weight, fu_psum_in}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rv = '{2, 8'h20, 1'b0, 1'b0, 64'h0403, 64'h0605, 27'd39, 6};
        run_vec(rv, "after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
